// File: rtl/complex_pkg.sv
// Shared types and helpers for the complex dot-product accumulator.
package complex_pkg;

    localparam int unsigned CMP_W      = 8;
    localparam int unsigned OP_W       = 2 * CMP_W;
    localparam int unsigned SEXT_MAX_W = 64;

    typedef struct packed {
        logic [CMP_W-1:0] x;
        logic [CMP_W-1:0] y;
    } cplx8_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } dot_state_t;

    // Sign-extend an 8-bit component; bits above 'width' are zeroed.
    function automatic logic [SEXT_MAX_W-1:0] sext8(input logic [CMP_W-1:0] v,
                                                    input int unsigned width);
        logic [SEXT_MAX_W-1:0] full;
        logic [SEXT_MAX_W-1:0] mask;
        full = {{(SEXT_MAX_W - CMP_W){v[CMP_W-1]}}, v};
        mask = (width >= SEXT_MAX_W) ? '1
             : ((SEXT_MAX_W'(1) << width) - SEXT_MAX_W'(1));
        return full & mask;
    endfunction

endpackage

// File: rtl/cplx_accum.sv
// Real/imag accumulator register pair with clear and enable; wraps modulo 2^ACC_W.
module cplx_accum #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] add_re,
    input  logic [ACC_W-1:0] add_im,
    output logic [ACC_W-1:0] sum_re_c,
    output logic [ACC_W-1:0] sum_im_c
);

    logic [ACC_W-1:0] acc_re;
    logic [ACC_W-1:0] acc_im;

    // Post-add sums are exposed so the final result can be registered on the last capture.
    assign sum_re_c = acc_re + add_re;
    assign sum_im_c = acc_im + add_im;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (clr) begin
            acc_re <= '0;
            acc_im <= '0;
        end else if (en) begin
            acc_re <= sum_re_c;
            acc_im <= sum_im_c;
        end
    end

endmodule

// File: rtl/complex_dot_acc.sv
// Feeds operand pairs to an external complex multiplier and accumulates N products
// into a complex dot product presented on a valid/ready output.
module complex_dot_acc
    import complex_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    output logic [OP_W-1:0]  mul_a,
    output logic [OP_W-1:0]  mul_b,
    output logic             mul_start,
    input  logic             mul_ready,
    input  logic [OP_W-1:0]  mul_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_re,
    output logic [ACC_W-1:0] out_im
);

    localparam int unsigned      CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    dot_state_t       state;
    dot_state_t       next_state;
    logic             first_wait_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    cplx8_t           prod;

    logic             accept_c;
    logic             capture_c;
    logic             last_c;
    logic             drain_c;

    logic [ACC_W-1:0] add_re;
    logic [ACC_W-1:0] add_im;
    logic [ACC_W-1:0] sum_re_c;
    logic [ACC_W-1:0] sum_im_c;

    logic             in_ready_d;
    logic             mul_start_d;
    logic             out_valid_d;
    logic [OP_W-1:0]  mul_a_d;
    logic [OP_W-1:0]  mul_b_d;
    logic [ACC_W-1:0] out_re_d;
    logic [ACC_W-1:0] out_im_d;

    assign prod      = cplx8_t'(mul_c);
    assign add_re    = ACC_W'(sext8(prod.x, ACC_W));
    assign add_im    = ACC_W'(sext8(prod.y, ACC_W));

    // The first WAIT cycle ignores mul_ready so a ready left over from a previous product is not taken.
    assign accept_c  = (state == IDLE) && in_valid && in_ready;
    assign capture_c = (state == WAIT) && !first_wait_q && mul_ready;
    assign last_c    = (cnt_q == LAST_CNT);
    assign drain_c   = (state == DONE) && out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_c) next_state = START;
            START:   next_state = WAIT;
            WAIT:    if (capture_c) next_state = last_c ? DONE : IDLE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = (next_state == IDLE);
        mul_start_d = (next_state == START);
        out_valid_d = (next_state == DONE);
        mul_a_d     = mul_a;
        mul_b_d     = mul_b;
        out_re_d    = out_re;
        out_im_d    = out_im;
        cnt_d       = cnt_q;
        if (accept_c) begin
            mul_a_d = in_a;
            mul_b_d = in_b;
        end
        if (capture_c && last_c) begin
            out_re_d = sum_re_c;
            out_im_d = sum_im_c;
        end
        if (drain_c) begin
            cnt_d = '0;
        end else if (capture_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready     <= 1'b0;
            mul_start    <= 1'b0;
            out_valid    <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            out_re       <= '0;
            out_im       <= '0;
            cnt_q        <= '0;
            first_wait_q <= 1'b0;
        end else begin
            in_ready     <= in_ready_d;
            mul_start    <= mul_start_d;
            out_valid    <= out_valid_d;
            mul_a        <= mul_a_d;
            mul_b        <= mul_b_d;
            out_re       <= out_re_d;
            out_im       <= out_im_d;
            cnt_q        <= cnt_d;
            first_wait_q <= (state == START);
        end
    end

    cplx_accum #(
        .ACC_W (ACC_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clr      (drain_c),
        .en       (capture_c),
        .add_re   (add_re),
        .add_im   (add_im),
        .sum_re_c (sum_re_c),
        .sum_im_c (sum_im_c)
    );

endmodule

// File: tb/tb_complex_dot_acc.sv
// Bench for complex_dot_acc: three configurations share one behavioural multiplier model.
module tb_complex_dot_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mul_c;
    logic        mul_ready;
    logic        out_ready;

    logic        in_ready_v  [3];
    logic [15:0] mul_a_v     [3];
    logic [15:0] mul_b_v     [3];
    logic        mul_start_v [3];
    logic        out_valid_v [3];
    logic [15:0] out_re_v    [3];
    logic [15:0] out_im_v    [3];
    logic [8:0]  re2;
    logic [8:0]  im2;

    int          total = 0;
    int          bad   = 0;
    int          starts [3];
    int          start_wide = 0;
    bit          prev_start [3];
    bit          stuck = 1'b0;

    always #5 clk = ~clk;

    assign out_re_v[2] = 16'(re2);
    assign out_im_v[2] = 16'(im2);

    complex_dot_acc #(.N(8), .ACC_W(16)) d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready_v[0]),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a_v[0]), .mul_b(mul_b_v[0]),
        .mul_start(mul_start_v[0]), .mul_ready(mul_ready), .mul_c(mul_c),
        .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .out_re(out_re_v[0]), .out_im(out_im_v[0]));

    complex_dot_acc #(.N(1), .ACC_W(16)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready_v[1]),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a_v[1]), .mul_b(mul_b_v[1]),
        .mul_start(mul_start_v[1]), .mul_ready(mul_ready), .mul_c(mul_c),
        .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .out_re(out_re_v[1]), .out_im(out_im_v[1]));

    complex_dot_acc #(.N(8), .ACC_W(9)) d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready_v[2]),
        .in_a(in_a), .in_b(in_b), .mul_a(mul_a_v[2]), .mul_b(mul_b_v[2]),
        .mul_start(mul_start_v[2]), .mul_ready(mul_ready), .mul_c(mul_c),
        .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .out_re(re2), .out_im(im2));

    // Complex product of packed 8-bit components, each part mod 256.
    function automatic logic [15:0] cmul(input logic [15:0] a, input logic [15:0] b);
        int ax, ay, bx, by, re, im;
        ax = int'($signed(a[15:8]));
        ay = int'($signed(a[7:0]));
        bx = int'($signed(b[15:8]));
        by = int'($signed(b[7:0]));
        re = ax * bx - ay * by;
        im = ax * by + ay * bx;
        return {8'(re), 8'(im)};
    endfunction

    // Start-pulse census: total pulses and any pulse longer than one cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mul_start_v[i]) starts[i] = starts[i] + 1;
            if (mul_start_v[i] && prev_start[i]) start_wide = start_wide + 1;
            prev_start[i] = mul_start_v[i];
        end
    end

    // Multiplier model: random latency, single-cycle ready; stuck mode holds ready high.
    initial begin
        int lat;
        logic [15:0] pa, pb;
        bit hit;
        mul_ready = 1'b0;
        mul_c     = 16'h0000;
        forever begin
            @(negedge clk);
            hit = 1'b0;
            pa  = 16'h0;
            pb  = 16'h0;
            for (int i = 0; i < 3; i++) begin
                if (mul_start_v[i] && rst) begin
                    hit = 1'b1;
                    pa  = mul_a_v[i];
                    pb  = mul_b_v[i];
                end
            end
            if (stuck) begin
                mul_ready = 1'b1;
                if (hit) begin
                    mul_c = 16'h5555;
                    @(posedge clk);
                    @(posedge clk);
                    #1;
                    mul_c = 16'h0203;
                end
            end else begin
                mul_ready = 1'b0;
                if (hit) begin
                    lat = int'($urandom_range(2, 5));
                    repeat (lat) @(negedge clk);
                    mul_c     = cmul(pa, pb);
                    mul_ready = 1'b1;
                    @(negedge clk);
                    mul_ready = 1'b0;
                    mul_c     = 16'($urandom);
                end
            end
        end
    end

    task automatic send_pair(input int s, input logic [15:0] a, input logic [15:0] b);
        int t;
        t = 0;
        in_a = a;
        in_b = b;
        in_valid[s] = 1'b1;
        while (!in_ready_v[s] && t < 200) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (in_ready_v[s] !== 1'b1) begin
            bad++;
            $display("FAIL send_timeout sel=%0d in_ready=%b required=1", s, in_ready_v[s]);
        end
        @(negedge clk);
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_valid(input int s);
        int t;
        t = 0;
        while (!out_valid_v[s] && t < 300) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (out_valid_v[s] !== 1'b1) begin
            bad++;
            $display("FAIL out_valid_timeout sel=%0d out_valid=%b required=1", s, out_valid_v[s]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 3'b000;
        in_a = 16'h0;
        in_b = 16'h0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (in_ready_v[i] !== 1'b0 || mul_start_v[i] !== 1'b0 || out_valid_v[i] !== 1'b0 ||
                mul_a_v[i] !== 16'h0 || mul_b_v[i] !== 16'h0 ||
                out_re_v[i] !== 16'h0 || out_im_v[i] !== 16'h0) begin
                bad++;
                $display("FAIL reset_outputs sel=%0d got rdy=%b st=%b ov=%b a=%h b=%h re=%h im=%h required all 0",
                         i, in_ready_v[i], mul_start_v[i], out_valid_v[i], mul_a_v[i], mul_b_v[i],
                         out_re_v[i], out_im_v[i]);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready_v[0] !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready got=%b required=1", in_ready_v[0]);
        end
    endtask

    task automatic test_single();
        int s0;
        s0 = starts[1];
        send_pair(1, 16'h0102, 16'h0304);
        wait_valid(1);
        total++;
        if (out_re_v[1] !== 16'hFFFB || out_im_v[1] !== 16'h000A) begin
            bad++;
            $display("FAIL single_result got=%h/%h required=fffb/000a", out_re_v[1], out_im_v[1]);
        end
        @(negedge clk);
        total++;
        if (out_valid_v[1] !== 1'b0 || starts[1] - s0 != 1) begin
            bad++;
            $display("FAIL single_pulse got valid=%b starts=%0d required valid=0 starts=1",
                     out_valid_v[1], starts[1] - s0);
        end
    endtask

    task automatic test_vector8();
        int s0, w0;
        s0 = starts[0];
        w0 = start_wide;
        for (int k = 0; k < 8; k++) send_pair(0, 16'h0102, 16'h0304);
        wait_valid(0);
        total++;
        if (out_re_v[0] !== 16'hFFD8 || out_im_v[0] !== 16'h0050) begin
            bad++;
            $display("FAIL vector8_result got=%h/%h required=ffd8/0050", out_re_v[0], out_im_v[0]);
        end
        @(negedge clk);
        total++;
        if (out_valid_v[0] !== 1'b0 || starts[0] - s0 != 8 || start_wide != w0) begin
            bad++;
            $display("FAIL vector8_pulses got valid=%b starts=%0d wide=%0d required 0/8/0",
                     out_valid_v[0], starts[0] - s0, start_wide - w0);
        end
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 8; k++) send_pair(2, 16'h0100, 16'h7F7F);
        wait_valid(2);
        total++;
        if (out_re_v[2] !== 16'h01F8 || out_im_v[2] !== 16'h01F8) begin
            bad++;
            $display("FAIL wrap_result got=%h/%h required=01f8/01f8", out_re_v[2], out_im_v[2]);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int sr, si, s0;
        logic [15:0] a, b, p, er, ei;
        sr = 0;
        si = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            p = cmul(a, b);
            sr += int'($signed(p[15:8]));
            si += int'($signed(p[7:0]));
            send_pair(0, a, b);
        end
        er = 16'(sr);
        ei = 16'(si);
        wait_valid(0);
        s0 = starts[0];
        in_a = 16'($urandom);
        in_b = 16'($urandom);
        in_valid[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid_v[0] !== 1'b1 || out_re_v[0] !== er || out_im_v[0] !== ei ||
                in_ready_v[0] !== 1'b0 || mul_start_v[0] !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got ov=%b re=%h im=%h rdy=%b st=%b required 1/%h/%h/0/0",
                         c, out_valid_v[0], out_re_v[0], out_im_v[0], in_ready_v[0],
                         mul_start_v[0], er, ei);
            end
        end
        in_valid[0] = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || starts[0] != s0 ||
            out_re_v[0] !== er || out_im_v[0] !== ei) begin
            bad++;
            $display("FAIL hold_release got ov=%b rdy=%b starts=%0d re=%h im=%h required 0/1/0/%h/%h",
                     out_valid_v[0], in_ready_v[0], starts[0] - s0, out_re_v[0], out_im_v[0], er, ei);
        end
    endtask

    task automatic test_stale_ready();
        stuck = 1'b1;
        @(negedge clk);
        send_pair(1, 16'h0000, 16'h0000);
        wait_valid(1);
        total++;
        if (out_re_v[1] !== 16'h0002 || out_im_v[1] !== 16'h0003) begin
            bad++;
            $display("FAIL stale_ready got=%h/%h required=0002/0003", out_re_v[1], out_im_v[1]);
        end
        stuck = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) send_pair(0, 16'($urandom), 16'($urandom));
        send_pair(0, 16'h1234, 16'h5678);
        rst = 1'b0;
        #1;
        total++;
        if (mul_start_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_start_drop got=%b required=0", mul_start_v[0]);
        end
        @(negedge clk);
        total++;
        if (out_valid_v[0] !== 1'b0 || out_re_v[0] !== 16'h0 || out_im_v[0] !== 16'h0 ||
            mul_a_v[0] !== 16'h0 || in_ready_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs got ov=%b re=%h im=%h a=%h rdy=%b required all 0",
                     out_valid_v[0], out_re_v[0], out_im_v[0], mul_a_v[0], in_ready_v[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 8; k++) send_pair(0, 16'h0100, 16'h0101);
        wait_valid(0);
        total++;
        if (out_re_v[0] !== 16'h0008 || out_im_v[0] !== 16'h0008) begin
            bad++;
            $display("FAIL reset_restart got=%h/%h required=0008/0008", out_re_v[0], out_im_v[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_random(input int s, input int n, input logic [15:0] mask);
        int sr, si;
        logic [15:0] a, b, p, er, ei;
        for (int v = 0; v < 2; v++) begin
            sr = 0;
            si = 0;
            for (int k = 0; k < n; k++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                p = cmul(a, b);
                sr += int'($signed(p[15:8]));
                si += int'($signed(p[7:0]));
                send_pair(s, a, b);
                total++;
                if (mul_a_v[s] !== a || mul_b_v[s] !== b) begin
                    bad++;
                    $display("FAIL rand_operands sel=%0d got=%h/%h required=%h/%h",
                             s, mul_a_v[s], mul_b_v[s], a, b);
                end
            end
            er = 16'(sr) & mask;
            ei = 16'(si) & mask;
            wait_valid(s);
            total++;
            if (out_re_v[s] !== er || out_im_v[s] !== ei) begin
                bad++;
                $display("FAIL rand_result sel=%0d vec=%0d got=%h/%h required=%h/%h",
                         s, v, out_re_v[s], out_im_v[s], er, ei);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_vector8();
        test_wrap();
        test_backpressure();
        test_stale_ready();
        test_reset_mid();
        test_random(0, 8, 16'hFFFF);
        test_random(1, 1, 16'hFFFF);
        test_random(2, 8, 16'h01FF);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/complex_dot_acc.md
Name: complex_dot_acc

Overview:
- Downstream consumer of the complex multiplier stage.
- Accepts a stream of complex operand pairs (a, b) over a valid/ready handshake and drives the multiplier's operand, start and ready handshake.
- Accumulates N products, sign-extended, into wide real/imag accumulators, then presents the complex dot product on a valid/ready output.
- Sits between the sample source and the multiplier, and feeds the result to the next datapath stage.

Parameters:
- N, 8: number of products per dot product. Legal range is N ≥ 1. Counter width is the derived localparam CNT_W = max(1, $clog2(N)).
- ACC_W, 16: width of each accumulator component. Must be ≥ 8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- in_a  in  16  operand a; [15:8] = real x, [7:0] = imag y, two's complement.
- in_b  in  16  operand b; same packing as in_a.
- mul_a  out  16  registered operand a to the multiplier.
- mul_b  out  16  registered operand b to the multiplier.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_ready  in  1  multiplier result valid.
- mul_c  in  16  multiplier product, packed like in_a, each component mod 256.
- out_valid  out  1  dot product valid.
- out_ready  in  1  downstream accepts the dot product.
- out_re  out  ACC_W  accumulated real part.
- out_im  out  ACC_W  accumulated imag part.

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to IDLE.
  - mul_start = 0, mul_a = mul_b = 0.
  - out_valid = 0, out_re = out_im = 0.
  - Accumulators and sample counter are cleared.
  - in_ready = 0 while rst = 0.
- State machine has four states: IDLE, START, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: register in_a → mul_a and in_b → mul_b, then go to START.
  - mul_ready is ignored in IDLE.
- START:
  - mul_start = 1 for exactly this one cycle. in_ready = 0.
  - Next state is WAIT.
- WAIT:
  - mul_start = 0. mul_a and mul_b are held stable.
  - The first WAIT cycle ignores mul_ready (stale-ready guard).
  - From the second WAIT cycle onward, on the first cycle with mul_ready = 1:
    - acc_re += sext(mul_c[15:8]).
    - acc_im += sext(mul_c[7:0]).
    - count += 1.
    - If the pre-increment count == N-1: register the post-add sums into out_re/out_im, set out_valid = 1, go to DONE.
    - Otherwise go to IDLE.
  - There is no timeout; the block waits indefinitely.
- DONE:
  - out_valid = 1. out_re and out_im are held stable. in_ready = 0.
  - On out_ready = 1 in the same cycle: out_valid = 0, accumulators and count cleared, go to IDLE.
  - out_re and out_im keep their last value until the next DONE.
- Arithmetic:
  - Accumulation is modular 2^ACC_W two's-complement wrap.
  - No saturation and no overflow flag.
- Throughput: one operand pair per (2 + multiplier latency + 1) cycles minimum. No overlap of samples.
- Output latency: out_valid rises on the cycle after the Nth capture.
- N = 1: every capture goes straight to DONE.
- out_ready held high: out_valid is asserted for exactly one cycle.
- in_valid while not in IDLE: no acceptance (in_ready = 0); the source must hold its data.
- Reset mid-operation (any state): partial sums are discarded and mul_start drops immediately. A following vector starts from zero.

Decomposition:
- Package complex_pkg:
  - typedef cplx8_t: struct packed {logic [7:0] x; logic [7:0] y;}.
  - State enum dot_state_t {IDLE, START, WAIT, DONE}.
  - Function sext8(logic [7:0], width).
- One sub-module, cplx_accum: real/imag accumulator register pair with clear, enable and ACC_W parameter.
- The multiplier instance stays outside this block; its connection is port-level.

Test Plan:
1. N=1, in_a=0x0102, in_b=0x0304, multiplier model → mul_c=0xFB0A → out_re=0xFFFB, out_im=0x000A, out_valid exactly 1 cycle with out_ready=1.
2. N=8, same pair ×8 → out_re=0xFFD8 (-40), out_im=0x0050 (80); mul_start pulses exactly 8 times, each 1 cycle wide.
3. ACC_W=9, N=8, mul_c=0x7F7F each → out_re=out_im=0x1F8 (1016 mod 512), confirming wrap.
4. out_ready low 5 cycles in DONE while in_valid=1 → out_valid, out_re and out_im stable; in_ready=0; no mul_start; then accept on out_ready=1 and return to IDLE.
5. mul_ready stuck high from the START cycle, model changes mul_c to 0x0203 one cycle after start → the captured value is 0x0203, not the stale value.
6. N=8: after 3 captures, pull rst low for 2 cycles → all outputs 0. Then 8 pairs each giving mul_c=0x0101 → out_re=out_im=0x0008.
